ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port 16-bit RAM between two requesters: m0 (instruction fetch) and m1 (data load/store).
- Arbitrates with round-robin, muxes address, rw and write data onto the RAM, and routes registered read data back with a valid pulse.
- Guarantees the RAM's rw line is READ whenever no write is granted, so the RAM never takes a spurious write.
- Sits between the core's fetch/LSU ports and the ram instance.

Parameters:
- ADDR_W, 16, address width (matches RAM addr).
- DATA_W, 16, data width (matches RAM mem_in/mem_out).
- MEM_SIZE, 255, first out-of-range address; writes at addr >= MEM_SIZE are suppressed.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  m0 access request, held until granted.
- m0_we  in  1  m0 write enable (1 = write, 0 = read).
- m0_addr  in  ADDR_W  m0 address.
- m0_wdata  in  DATA_W  m0 write data.
- m0_gnt  out  1  m0 granted this cycle (combinational).
- m0_rvalid  out  1  m0 read data valid (1-cycle pulse).
- m0_rdata  out  DATA_W  m0 read data.
- m0_err  out  1  m0 out-of-range write dropped (1-cycle pulse).
- m1_*  same set as m0 for requester 1.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_rw  out  1  to RAM rw (0 READ, 1 WRITE).
- ram_wdata  out  DATA_W  to RAM mem_in.
- ram_rdata  in  DATA_W  from RAM mem_out.

Behaviour:
- Reset (rst_n low, async):
  - rr_ptr=0 (m0 preferred first); rd_pend=0; rd_id=0.
  - All gnt/rvalid/err = 0; rdata = 0.
  - ram_rw is forced 0 while in reset, regardless of requests.
- Arbitration, cycle N (combinational):
  - Only one requester active: it is granted.
  - Both active: the one indicated by rr_ptr is granted.
  - At the posedge ending cycle N, rr_ptr is set to the non-granted requester.
  - No grant: rr_ptr is unchanged.
- RAM drive during cycle N:
  - ram_addr and ram_wdata come from the granted requester.
  - ram_rw = granted_we AND (addr < MEM_SIZE).
  - Idle: ram_addr holds its last value (registered hold); ram_rw=0; ram_wdata=0.
- Reads: one access per cycle; no read gap is inserted between requesters.
  - A read granted in cycle N sets rd_pend=1 and rd_id=grantee at the posedge ending N.
  - In cycle N+1, only the rd_id requester sees rvalid=1 with rdata=ram_rdata. The RAM's registered output makes the latency exactly 1 cycle.
  - rdata of the other requester is held at its last value.
  - An out-of-range read is passed through; the RAM returns 0.
- Writes: complete at the posedge ending cycle N; no rvalid.
- Out-of-range write (we=1, addr >= MEM_SIZE):
  - Still granted (the handshake completes) with ram_rw=0.
  - err pulses in cycle N+1 for the grantee.
- Back-to-back: a requester holding req is granted every cycle if the other is idle. It alternates with the other when both are active, so worst-case wait is 1 cycle.
- Read then write to the same address in consecutive cycles: the read returns the old data (the RAM read is registered before the write edge).
- A requester deasserting req before gnt: the request is simply dropped; there is no state.
- Reset asserted mid-read (between grant and rvalid): rd_pend is cleared and the rvalid pulse never appears.

Decomposition:
- ram_arb_pkg holds:
  - READ=1'b0, WRITE=1'b1 constants.
  - Requester ID constants M0=1'b0, M1=1'b1.
  - Default widths.
- One sub-module: rr_arb2, a 2-way round-robin arbiter. It holds rr_ptr and produces a one-hot grant plus a grant-valid output.
- The top module holds the muxing, the range check, and the rd_pend/rd_id/err pipeline.

Test Plan:
- Reset with m0_req=1, m0_we=1 held -> ram_rw=0 and m0_gnt=0 throughout reset; first grant comes on the first cycle after release.
- m0 writes 0xBEEF to addr 5, then reads addr 5 -> m0_gnt each cycle; m0_rvalid=1, m0_rdata=0xBEEF in the cycle after the read grant; m1_rvalid stays 0.
- m0 and m1 both read continuously (addr 1 and 2, preloaded 0x1111/0x2222) -> grants alternate m0,m1,m0,...; rvalid/rdata alternate correctly one cycle later.
- m1 writes 0x1234 to addr 300 -> m1_gnt=1 and ram_rw=0; m1_err pulses the next cycle; a later read of addr 300 returns 0.
- rst_n pulsed low in the cycle after an m1 read grant -> no m1_rvalid; after release rr_ptr=0, and with both requesting, m0 is granted first.
- Idle for 10 cycles with no requests -> ram_rw=0 every cycle; RAM contents unchanged.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-requester RAM arbiter.
// Widths default to the 16-bit RAM the arbiter fronts.
package ram_arb_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int MEM_SIZE_DEF = 255;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/ram_arb_if.sv
// Bundle of both requester ports plus the RAM-side bus.
// slave = arbiter view, master = core/RAM side view.
interface ram_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rw;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  m0_req,
        input  m0_we,
        input  m0_addr,
        input  m0_wdata,
        output m0_gnt,
        output m0_rvalid,
        output m0_rdata,
        output m0_err,
        input  m1_req,
        input  m1_we,
        input  m1_addr,
        input  m1_wdata,
        output m1_gnt,
        output m1_rvalid,
        output m1_rdata,
        output m1_err,
        output ram_addr,
        output ram_rw,
        output ram_wdata,
        input  ram_rdata
    );

    modport master (
        output m0_req,
        output m0_we,
        output m0_addr,
        output m0_wdata,
        input  m0_gnt,
        input  m0_rvalid,
        input  m0_rdata,
        input  m0_err,
        output m1_req,
        output m1_we,
        output m1_addr,
        output m1_wdata,
        input  m1_gnt,
        input  m1_rvalid,
        input  m1_rdata,
        input  m1_err,
        input  ram_addr,
        input  ram_rw,
        input  ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; r_ptr names the requester that
// wins the next contested cycle.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_gnt_vld
);

    logic r_ptr;

    // Grants are masked while reset is held so nothing reaches the RAM.
    always_comb begin
        o_gnt = 2'b00;
        if (rst_n) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = (r_ptr == M1) ? 2'b10 : 2'b01;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    assign o_gnt_vld = |o_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= M0;
        end else if (o_gnt_vld) begin
            r_ptr <= o_gnt[0] ? M1 : M0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between fetch (m0) and LSU (m1):
// grant, mux, range check, and the read/err return pipeline.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    ram_arb_if.slave bus
);

    localparam logic [ADDR_W:0] W_LIM = (ADDR_W+1)'(MEM_SIZE);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_gvld;
    logic              w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_inrange;
    logic              w_wr_ok;
    logic              w_wr_bad;
    logic              w_rd;
    logic              w_rv0;
    logic              w_rv1;

    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_pend;
    logic              r_rd_id;
    logic [1:0]        r_err;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    assign w_req = {bus.m1_req, bus.m0_req};

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req),
        .o_gnt     (w_gnt),
        .o_gnt_vld (w_gvld)
    );

    assign w_sel = w_gnt[1] ? M1 : M0;

    always_comb begin
        w_we    = bus.m0_we;
        w_addr  = bus.m0_addr;
        w_wdata = bus.m0_wdata;
        if (w_sel == M1) begin
            w_we    = bus.m1_we;
            w_addr  = bus.m1_addr;
            w_wdata = bus.m1_wdata;
        end
    end

    assign w_inrange = {1'b0, w_addr} < W_LIM;

    assign w_rd     = w_gvld && (w_we == READ);
    assign w_wr_ok  = w_gvld && (w_we == WRITE) && w_inrange;
    assign w_wr_bad = w_gvld && (w_we == WRITE) && !w_inrange;

    // The address is held when idle so the RAM input stays quiet.
    assign bus.ram_addr  = w_gvld ? w_addr : r_addr;
    assign bus.ram_rw    = w_wr_ok ? WRITE : READ;
    assign bus.ram_wdata = w_gvld ? w_wdata : '0;

    assign bus.m0_gnt = w_gnt[0];
    assign bus.m1_gnt = w_gnt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_rd_pend <= 1'b0;
            r_rd_id   <= M0;
            r_err     <= 2'b00;
        end else begin
            if (w_gvld) begin
                r_addr <= w_addr;
            end
            r_rd_pend <= w_rd;
            if (w_rd) begin
                r_rd_id <= w_sel;
            end
            r_err[0] <= w_wr_bad && (w_sel == M0);
            r_err[1] <= w_wr_bad && (w_sel == M1);
        end
    end

    // RAM output is registered, so read data lines up one cycle later.
    assign w_rv0 = r_rd_pend && (r_rd_id == M0);
    assign w_rv1 = r_rd_pend && (r_rd_id == M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_rv0) begin
                r_rdata0 <= bus.ram_rdata;
            end
            if (w_rv1) begin
                r_rdata1 <= bus.ram_rdata;
            end
        end
    end

    assign bus.m0_rvalid = w_rv0;
    assign bus.m1_rvalid = w_rv1;
    assign bus.m0_rdata  = w_rv0 ? bus.ram_rdata : r_rdata0;
    assign bus.m1_rdata  = w_rv1 ? bus.ram_rdata : r_rdata1;
    assign bus.m0_err    = r_err[0];
    assign bus.m1_err    = r_err[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vectors, a behavioural RAM,
// and a cycle model checked on every falling edge.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_errs   = 0;

    ram_arb_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    ram_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .MEM_SIZE (255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read-before-write, 0 beyond the array.
    logic [15:0] ram_mem [0:254];
    logic [15:0] ram_q = 16'h0;

    always @(posedge clk) begin
        if (bus.ram_addr < 16'd255) begin
            ram_q <= ram_mem[bus.ram_addr[7:0]];
            if (bus.ram_rw) ram_mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
        end else begin
            ram_q <= 16'h0;
        end
    end

    assign bus.ram_rdata = ram_q;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who wins, what the RAM sees, what returns next cycle.
    logic [15:0] ref_mem [0:254] = '{default: 16'h0};
    int          pref     = 0;
    bit          pend_v   = 0;
    int          pend_id  = 0;
    logic [15:0] pend_d   = 16'h0;
    bit          err_v    = 0;
    int          err_id   = 0;
    logic [15:0] hold [2] = '{16'h0, 16'h0};
    logic [15:0] last_a   = 16'h0;

    always @(negedge clk) begin
        logic        rq [2];
        logic        we [2];
        logic [15:0] ad [2];
        logic [15:0] wd [2];
        logic        gt [2];
        logic        rv [2];
        logic        er [2];
        logic [15:0] rd [2];
        int          w;
        bit          inr;
        rq = '{bus.m0_req, bus.m1_req};
        we = '{bus.m0_we, bus.m1_we};
        ad = '{bus.m0_addr, bus.m1_addr};
        wd = '{bus.m0_wdata, bus.m1_wdata};
        gt = '{bus.m0_gnt, bus.m1_gnt};
        rv = '{bus.m0_rvalid, bus.m1_rvalid};
        er = '{bus.m0_err, bus.m1_err};
        rd = '{bus.m0_rdata, bus.m1_rdata};
        if (!rst_n) begin
            check("rst_ram_rw", 32'(bus.ram_rw), 0);
            for (int k = 0; k < 2; k++) begin
                check("rst_gnt", 32'(gt[k]), 0);
                check("rst_rvalid", 32'(rv[k]), 0);
                check("rst_err", 32'(er[k]), 0);
                check("rst_rdata", 32'(rd[k]), 0);
            end
            pref   = 0;
            pend_v = 0;
            err_v  = 0;
            hold   = '{16'h0, 16'h0};
            last_a = 16'h0;
        end else begin
            w = -1;
            if (rq[0] && rq[1]) w = pref;
            else if (rq[0])     w = 0;
            else if (rq[1])     w = 1;
            inr = (w >= 0) && (ad[w] < 16'd255);
            check("m0_gnt", 32'(gt[0]), 32'(w == 0));
            check("m1_gnt", 32'(gt[1]), 32'(w == 1));
            check("ram_rw", 32'(bus.ram_rw), 32'((w >= 0) && we[w] && inr));
            check("ram_addr", 32'(bus.ram_addr), 32'((w >= 0) ? ad[w] : last_a));
            check("ram_wdata", 32'(bus.ram_wdata), 32'((w >= 0) ? wd[w] : 16'h0));
            for (int k = 0; k < 2; k++) begin
                bit ev;
                ev = pend_v && (pend_id == k);
                check("rvalid", 32'(rv[k]), 32'(ev));
                check("rdata", 32'(rd[k]), 32'(ev ? pend_d : hold[k]));
                if (ev) hold[k] = pend_d;
                check("err", 32'(er[k]), 32'(err_v && (err_id == k)));
            end
            pend_v = 0;
            err_v  = 0;
            if (w >= 0) begin
                last_a = ad[w];
                pref   = 1 - w;
                if (!we[w]) begin
                    pend_v  = 1;
                    pend_id = w;
                    pend_d  = inr ? ref_mem[ad[w][7:0]] : 16'h0;
                end else if (inr) begin
                    ref_mem[ad[w][7:0]] = wd[w];
                end else begin
                    err_v  = 1;
                    err_id = w;
                end
            end
        end
    end

    task automatic set0(input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
        bus.m0_req = r; bus.m0_we = w; bus.m0_addr = a; bus.m0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
        bus.m1_req = r; bus.m1_we = w; bus.m1_addr = a; bus.m1_wdata = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set0(1, 1, 16'd5, 16'hBEEF);
        set1(0, 0, 16'd0, 16'h0);
        repeat (3) begin
            @(negedge clk);
            check("lit_rst_m0_gnt", 32'(bus.m0_gnt), 0);
            check("lit_rst_ram_rw", 32'(bus.ram_rw), 0);
        end
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        check("lit_first_gnt", 32'(bus.m0_gnt), 1);
        check("lit_first_rw", 32'(bus.ram_rw), 1);

        cyc(); set0(1, 0, 16'd5, 16'h0);
        @(negedge clk);
        check("lit_rd5_gnt", 32'(bus.m0_gnt), 1);
        cyc(); set0(0, 0, 16'd0, 16'h0);
        @(negedge clk);
        check("lit_rd5_rvalid", 32'(bus.m0_rvalid), 1);
        check("lit_rd5_rdata", 32'(bus.m0_rdata), 32'hBEEF);
        check("lit_rd5_m1_rvalid", 32'(bus.m1_rvalid), 0);

        // Both write at once; pointer favours m1 after m0's last grant.
        cyc(); set0(1, 1, 16'd1, 16'h1111); set1(1, 1, 16'd2, 16'h2222);
        @(negedge clk);
        check("lit_wr_m1_first", 32'(bus.m1_gnt), 1);
        cyc(); set1(0, 0, 16'd0, 16'h0);
        @(negedge clk);
        check("lit_wr_m0_next", 32'(bus.m0_gnt), 1);

        cyc(); set0(1, 0, 16'd1, 16'h0); set1(1, 0, 16'd2, 16'h0);
        @(negedge clk);
        check("lit_alt_c1", 32'(bus.m1_gnt), 1);
        cyc();
        @(negedge clk);
        check("lit_alt_c2_gnt", 32'(bus.m0_gnt), 1);
        check("lit_alt_c2_rd", 32'(bus.m1_rdata), 32'h2222);
        cyc();
        @(negedge clk);
        check("lit_alt_c3_gnt", 32'(bus.m1_gnt), 1);
        check("lit_alt_c3_rd", 32'(bus.m0_rdata), 32'h1111);
        repeat (3) cyc();

        cyc(); set0(0, 0, 16'd0, 16'h0); set1(1, 1, 16'd300, 16'h1234);
        @(negedge clk);
        check("lit_oor_gnt", 32'(bus.m1_gnt), 1);
        check("lit_oor_rw", 32'(bus.ram_rw), 0);
        cyc(); set1(1, 0, 16'd300, 16'h0);
        @(negedge clk);
        check("lit_oor_err", 32'(bus.m1_err), 1);
        cyc(); set1(0, 0, 16'd0, 16'h0);
        @(negedge clk);
        check("lit_oor_rvalid", 32'(bus.m1_rvalid), 1);
        check("lit_oor_rdata", 32'(bus.m1_rdata), 0);
        check("lit_oor_err_end", 32'(bus.m1_err), 0);

        // Reset lands between an m1 read grant and its data.
        cyc(); set1(1, 0, 16'd2, 16'h0);
        @(negedge clk);
        check("lit_mid_gnt", 32'(bus.m1_gnt), 1);
        cyc(); rst_n = 1'b0; set0(1, 0, 16'd1, 16'h0);
        @(negedge clk);
        check("lit_mid_no_rvalid", 32'(bus.m1_rvalid), 0);
        cyc();
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        check("lit_post_m0", 32'(bus.m0_gnt), 1);
        check("lit_post_m1", 32'(bus.m1_gnt), 0);
        cyc();
        @(negedge clk);
        check("lit_post_m1_next", 32'(bus.m1_gnt), 1);
        check("lit_post_rd", 32'(bus.m0_rdata), 32'h1111);
        cyc(); set0(0, 0, 16'd0, 16'h0); set1(0, 0, 16'd0, 16'h0);
        @(negedge clk);
        check("lit_post_rd1", 32'(bus.m1_rdata), 32'h2222);

        repeat (10) begin
            cyc();
            @(negedge clk);
            check("lit_idle_rw", 32'(bus.ram_rw), 0);
        end

        // Read then write the same word: the read sees the old value.
        cyc(); set0(1, 0, 16'd5, 16'h0);
        cyc(); set0(1, 1, 16'd5, 16'hCAFE);
        @(negedge clk);
        check("lit_raw_old", 32'(bus.m0_rdata), 32'hBEEF);
        cyc(); set0(1, 0, 16'd5, 16'h0);
        cyc(); set0(0, 0, 16'd0, 16'h0);
        @(negedge clk);
        check("lit_raw_new", 32'(bus.m0_rdata), 32'hCAFE);
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
